// File: rtl/uart_rx_pkg.sv
// ============================================================================
// Module : uart_rx_pkg
// Brief  : Shared types and constants for the UART receive path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_rx_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_BIT_IDX_W = $clog2(UART_DATA_BITS);

  // The idle level of the serial line; synchroniser flops reset to it.
  localparam logic UART_LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    UART_ST_IDLE   = 3'd0,
    UART_ST_START  = 3'd1,
    UART_ST_DATA   = 3'd2,
    UART_ST_PARITY = 3'd3,
    UART_ST_STOP   = 3'd4
  } uart_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx_if.sv
// ============================================================================
// Module : uart_rx_if
// Brief  : Byte holding-register handshake and status pulses of uart_rx.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_rx_if;
  import uart_rx_pkg::*;

  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      rx_valid;
  logic                      rx_ready;
  logic                      frame_err;
  logic                      overrun;
  logic                      parity_err;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    output frame_err,
    output overrun,
    output parity_err
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    input  frame_err,
    input  overrun,
    input  parity_err
  );

endinterface

`default_nettype wire

// File: rtl/uart_rx_sync_2ff.sv
// ============================================================================
// Module : uart_rx_sync_2ff
// Brief  : Two-flop synchroniser with a parameterised reset level.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module : uart_rx
// Brief  : 8N1 serial receiver with a one-entry valid/ready holding register.
//          Define UART_RX_PARITY_EN to add an even-parity bit after the data.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DIV_W   = 16,
  parameter int DIV_MIN = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ser_rx,
  input  logic [DIV_W-1:0] cfg_div,
  uart_rx_if.master        rx_if
);

  logic                      w_rx_s;
  logic                      w_fall;
  logic [DIV_W-1:0]          w_div_clamped;
  logic                      w_half_tick;
  logic                      w_bit_tick;
  logic                      w_accept;
  logic                      w_can_load;

  uart_state_t               r_state;
  logic                      r_prev;
  logic [DIV_W-1:0]          r_div;
  logic [DIV_W-1:0]          r_cnt;
  logic [UART_BIT_IDX_W-1:0] r_bit;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] r_data;
  logic                      r_valid;
  logic                      r_ferr;
  logic                      r_ovr;
`ifdef UART_RX_PARITY_EN
  logic                      r_perr;
  logic                      r_par_bad;
`endif

  uart_rx_sync_2ff #(
    .RESET_VAL (UART_LINE_IDLE)
  ) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .i_d    (ser_rx),
    .o_q    (w_rx_s)
  );

  assign w_fall        = r_prev & ~w_rx_s;
  assign w_div_clamped = (cfg_div < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : cfg_div;
  assign w_half_tick   = (r_cnt == ((r_div >> 1) - DIV_W'(1)));
  assign w_bit_tick    = (r_cnt == (r_div - DIV_W'(1)));
  assign w_accept      = r_valid & rx_if.rx_ready;
  assign w_can_load    = ~r_valid | w_accept;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= UART_ST_IDLE;
      r_prev    <= UART_LINE_IDLE;
      r_div     <= DIV_W'(DIV_MIN);
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovr     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr    <= 1'b0;
      r_par_bad <= 1'b0;
`endif
    end else begin
      r_prev <= w_rx_s;
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr <= 1'b0;
`endif
      if (w_accept) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        UART_ST_IDLE: begin
          // Edge-triggered so a line stuck low cannot start repeated frames.
          if (w_fall) begin
            r_state <= UART_ST_START;
            r_cnt   <= '0;
            r_div   <= w_div_clamped;
          end
        end

        UART_ST_START: begin
          if (w_half_tick) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= w_rx_s ? UART_ST_IDLE : UART_ST_DATA;
          end else begin
            r_cnt <= r_cnt + DIV_W'(1);
          end
        end

        UART_ST_DATA: begin
          if (w_bit_tick) begin
            r_cnt   <= '0;
            r_shift <= {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
            r_bit   <= r_bit + UART_BIT_IDX_W'(1);
            if (r_bit == UART_BIT_IDX_W'(UART_DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              r_state <= UART_ST_PARITY;
`else
              r_state <= UART_ST_STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt + DIV_W'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        UART_ST_PARITY: begin
          if (w_bit_tick) begin
            r_cnt     <= '0;
            r_par_bad <= ^{r_shift, w_rx_s};
            r_state   <= UART_ST_STOP;
          end else begin
            r_cnt <= r_cnt + DIV_W'(1);
          end
        end
`endif

        UART_ST_STOP: begin
          // Leave mid-stop-bit so a back-to-back start edge is not missed.
          if (w_bit_tick) begin
            r_cnt   <= '0;
            r_state <= UART_ST_IDLE;
            if (!w_rx_s) begin
              r_ferr <= 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            else if (r_par_bad) begin
              r_perr <= 1'b1;
            end
`endif
            else if (w_can_load) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
            end else begin
              r_ovr <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + DIV_W'(1);
          end
        end

        default: begin
          r_state <= UART_ST_IDLE;
        end
      endcase
    end
  end

  assign rx_if.rx_data   = r_data;
  assign rx_if.rx_valid  = r_valid;
  assign rx_if.frame_err = r_ferr;
  assign rx_if.overrun   = r_ovr;
`ifdef UART_RX_PARITY_EN
  assign rx_if.parity_err = r_perr;
`else
  assign rx_if.parity_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module : tb_uart_rx
// Brief  : Directed self-checking bench for uart_rx.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

  logic        clk;
  logic        resetn;
  logic        ser_rx;
  logic [15:0] cfg_div;

  uart_rx_if u_if ();

  uart_rx #(
    .DIV_W   (16),
    .DIV_MIN (4)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .ser_rx  (ser_rx),
    .cfg_div (cfg_div),
    .rx_if   (u_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Event counters kept by the monitor; tests work on deltas.
  int       cyc      = 0;
  int       n_vcyc   = 0;
  int       n_acc    = 0;
  int       n_ferr   = 0;
  int       n_ovr    = 0;
  int       n_perr   = 0;
  int       t_rise   = 0;
  int       t_edge   = 0;
  logic [7:0] last_acc = 8'h00;
  logic     prev_v   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (u_if.rx_valid) n_vcyc <= n_vcyc + 1;
    if (u_if.rx_valid && !prev_v) t_rise <= cyc;
    if (u_if.rx_valid && u_if.rx_ready) begin
      n_acc    <= n_acc + 1;
      last_acc <= u_if.rx_data;
    end
    if (u_if.frame_err)  n_ferr <= n_ferr + 1;
    if (u_if.overrun)    n_ovr  <= n_ovr + 1;
    if (u_if.parity_err) n_perr <= n_perr + 1;
    prev_v <= u_if.rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    ser_rx = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par, input int n);
    @(posedge clk);
    #1;
    t_edge = cyc;
    drive_bit(1'b0, n);
    for (int i = 0; i < 8; i++) drive_bit(d[i], n);
`ifdef UART_RX_PARITY_EN
    drive_bit(par, n);
`else
    if (par === 1'bx) $display("note: unknown parity argument");
`endif
    drive_bit(stop, n);
    ser_rx = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int v0, a0, f0, o0, p0, lat;

  initial begin
    resetn        = 1'b0;
    ser_rx        = 1'b1;
    cfg_div       = 16'd16;
    u_if.rx_ready = 1'b1;

    #3;
    chk("rst_data",  {24'd0, u_if.rx_data}, 32'h00);
    chk("rst_valid", {31'd0, u_if.rx_valid}, 32'd0);
    chk("rst_ferr",  {31'd0, u_if.frame_err}, 32'd0);
    chk("rst_ovr",   {31'd0, u_if.overrun}, 32'd0);
    chk("rst_perr",  {31'd0, u_if.parity_err}, 32'd0);
    idle(4);
    resetn = 1'b1;
    idle(10);

    // Frame 0xA5, consumer always ready.
    v0 = n_vcyc; f0 = n_ferr + n_ovr + n_perr;
    send_frame(8'hA5, 1'b1, ^8'hA5, 16);
    idle(10);
    lat = t_rise - t_edge;
    chk("a5_valid_cycles", n_vcyc - v0, 1);
    chk("a5_data", {24'd0, last_acc}, 32'hA5);
    chk("a5_latency_in_window", {31'd0, (lat >= 154 && lat <= 156)}, 32'd1);
    chk("a5_no_errors", n_ferr + n_ovr + n_perr - f0, 0);

    // Short low glitch must be ignored.
    v0 = n_vcyc; f0 = n_ferr + n_ovr + n_perr;
    ser_rx = 1'b0;
    idle(4);
    ser_rx = 1'b1;
    idle(40);
    chk("glitch_no_valid", n_vcyc - v0, 0);
    chk("glitch_no_pulse", n_ferr + n_ovr + n_perr - f0, 0);
    a0 = n_acc;
    send_frame(8'h3C, 1'b1, ^8'h3C, 16);
    idle(10);
    chk("after_glitch_count", n_acc - a0, 1);
    chk("after_glitch_data", {24'd0, last_acc}, 32'h3C);

    // Bad stop bit.
    v0 = n_vcyc; f0 = n_ferr;
    send_frame(8'h55, 1'b0, ^8'h55, 16);
    idle(10);
    chk("ferr_pulse", n_ferr - f0, 1);
    chk("ferr_no_valid", n_vcyc - v0, 0);
    a0 = n_acc;
    send_frame(8'h01, 1'b1, ^8'h01, 16);
    idle(10);
    chk("after_ferr_data", {24'd0, last_acc}, 32'h01);
    chk("after_ferr_count", n_acc - a0, 1);

    // Back-to-back frames with the consumer stalled.
    u_if.rx_ready = 1'b0;
    o0 = n_ovr;
    send_frame(8'h12, 1'b1, ^8'h12, 16);
    send_frame(8'h34, 1'b1, ^8'h34, 16);
    idle(10);
    chk("ovr_pulse", n_ovr - o0, 1);
    chk("ovr_valid_held", {31'd0, u_if.rx_valid}, 32'd1);
    chk("ovr_data_kept", {24'd0, u_if.rx_data}, 32'h12);
    u_if.rx_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("ovr_read_data", {24'd0, last_acc}, 32'h12);
    chk("ovr_valid_clear", {31'd0, u_if.rx_valid}, 32'd0);
    idle(10);

    // cfg_div below the minimum is clamped to 4 clocks per bit.
    cfg_div = 16'd2;
    a0 = n_acc; f0 = n_ferr;
    send_frame(8'hFF, 1'b1, ^8'hFF, 4);
    idle(10);
    chk("clamp_count", n_acc - a0, 1);
    chk("clamp_data", {24'd0, last_acc}, 32'hFF);
    chk("clamp_no_ferr", n_ferr - f0, 0);
    cfg_div = 16'd16;
    idle(5);

    // Asynchronous reset in the middle of data bit 3.
    @(posedge clk);
    #1;
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 16);
    drive_bit(1'b1, 16);
    drive_bit(1'b1, 16);
    drive_bit(1'b1, 8);
    resetn = 1'b0;
    #2;
    chk("mid_rst_data",  {24'd0, u_if.rx_data}, 32'h00);
    chk("mid_rst_valid", {31'd0, u_if.rx_valid}, 32'd0);
    chk("mid_rst_pulses", {29'd0, u_if.frame_err, u_if.overrun, u_if.parity_err}, 32'd0);
    ser_rx = 1'b1;
    idle(3);
    resetn = 1'b1;
    idle(5);
    a0 = n_acc;
    send_frame(8'h80, 1'b1, ^8'h80, 16);
    idle(10);
    chk("post_rst_count", n_acc - a0, 1);
    chk("post_rst_data", {24'd0, last_acc}, 32'h80);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity needs a 1 in the parity slot.
    v0 = n_vcyc; p0 = n_perr;
    send_frame(8'h07, 1'b1, 1'b0, 16);
    idle(10);
    chk("par_err_pulse", n_perr - p0, 1);
    chk("par_err_no_valid", n_vcyc - v0, 0);
    a0 = n_acc;
    send_frame(8'h07, 1'b1, 1'b1, 16);
    idle(10);
    chk("par_ok_count", n_acc - a0, 1);
    chk("par_ok_data", {24'd0, last_acc}, 32'h07);
`else
    p0 = n_perr;
    idle(2);
    chk("no_parity_pulses", n_perr - p0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
